// File: rtl/ytydla_cacc_pkg.sv
// Shared types and defaults for the CACC adder-tree sequencer.
// Also supplies a default datapath width when the core-wide define is absent.
`ifndef YTYDLA_DATA_LENGTH
`define YTYDLA_DATA_LENGTH 32
`endif

package ytydla_cacc_pkg;

  localparam int CACC_CNT_W    = 16;
  localparam int CACC_ADDR_W   = 16;
  localparam int CACC_TREE_LAT = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_BIAS_REQ,
    ST_BIAS_WAIT,
    ST_ACC,
    ST_OUT
  } cacc_ctrl_state_e;

  // Layer configuration captured on an accepted start.
  typedef struct packed {
    logic [CACC_CNT_W-1:0]  atoms;
    logic [CACC_CNT_W-1:0]  outputs;
    logic [CACC_ADDR_W-1:0] bias_base;
  } cacc_cfg_t;

endpackage

// File: rtl/ytydla_conv_cacc_ctrl_if.sv
// Datapath handshakes around the CACC sequencer: CMAC beats, bias memory,
// adder-tree result and the CACT output channel.
interface ytydla_conv_cacc_ctrl_if #(
  parameter int DATA_W = `YTYDLA_DATA_LENGTH,
  parameter int ADDR_W = ytydla_cacc_pkg::CACC_ADDR_W
);
  logic              cmac2cacc_valid;
  logic              cacc2cmac_ready;
  logic              cacc2mem_bias_req;
  logic [ADDR_W-1:0] cacc2mem_bias_addr;
  logic              mem2cacc_bias_valid;
  logic [DATA_W-1:0] mem2cacc_bias;
  logic [DATA_W-1:0] tree_sum;
  logic [DATA_W-1:0] cacc2cact_dat;
  logic              cacc2cact_valid;
  logic              cact2cacc_ready;

  // The sequencer side.
  modport master (
    input  cmac2cacc_valid, mem2cacc_bias_valid, mem2cacc_bias, tree_sum, cact2cacc_ready,
    output cacc2cmac_ready, cacc2mem_bias_req, cacc2mem_bias_addr, cacc2cact_dat, cacc2cact_valid
  );

  // CMAC, bias memory, adder tree and CACT seen together.
  modport slave (
    output cmac2cacc_valid, mem2cacc_bias_valid, mem2cacc_bias, tree_sum, cact2cacc_ready,
    input  cacc2cmac_ready, cacc2mem_bias_req, cacc2mem_bias_addr, cacc2cact_dat, cacc2cact_valid
  );
endinterface

// File: rtl/ytydla_cacc_valid_delay.sv
// In-flight tracker for the fixed-latency adder tree: a 1 enters per accepted
// beat and emerges on tail exactly DEPTH cycles later, when its sum is on tree_sum.
module ytydla_cacc_valid_delay #(
  parameter int DEPTH = ytydla_cacc_pkg::CACC_TREE_LAT
) (
  input  logic ytydla_core_clk,
  input  logic ytydla_core_rst,
  input  logic push,
  output logic tail
);

  logic [DEPTH-1:0] sr;

  // The shift form keeps DEPTH=1 legal without a special case.
  always_ff @(posedge ytydla_core_clk) begin
    if (ytydla_core_rst) begin
      sr <= '0;
    end else begin
      sr <= (sr << 1) | DEPTH'(push);
    end
  end

  assign tail = sr[DEPTH-1];

endmodule

// File: rtl/ytydla_conv_cacc_ctrl.sv
// CACC sequencer: per output, fetch the bias, meter CMAC beats into the adder
// tree, accumulate the tree sums on top of the bias and hand the result to CACT.
module ytydla_conv_cacc_ctrl
  import ytydla_cacc_pkg::*;
#(
  parameter int DATA_W   = `YTYDLA_DATA_LENGTH,
  parameter int TREE_LAT = CACC_TREE_LAT,
  parameter int CNT_W    = CACC_CNT_W,
  parameter int ADDR_W   = CACC_ADDR_W
) (
  input  logic              ytydla_core_clk,
  input  logic              ytydla_core_rst,
  input  logic              cfg_start,
  input  logic [CNT_W-1:0]  cfg_atoms,
  input  logic [CNT_W-1:0]  cfg_outputs,
  input  logic [ADDR_W-1:0] cfg_bias_base,
  output logic              ctrl_busy,
  output logic              ctrl_done,
  ytydla_conv_cacc_ctrl_if.master bus
);

  cacc_ctrl_state_e  state;
  cacc_cfg_t         cfg_q;
  logic [CNT_W-1:0]  out_cnt;
  logic [CNT_W-1:0]  issue_cnt;
  logic [CNT_W-1:0]  recv_cnt;
  logic [DATA_W-1:0] acc;

  logic              busy_q;
  logic              done_q;
  logic              req_q;
  logic [ADDR_W-1:0] addr_q;
  logic              valid_q;
  logic [DATA_W-1:0] dat_q;

  logic              cmac_ready;
  logic              beat;
  logic              tail;
  logic [CNT_W-1:0]  out_cnt_inc;
  logic [CNT_W-1:0]  recv_cnt_nxt;
  logic [DATA_W-1:0] acc_nxt;

  // Reset gates ready directly so no beat can slip in on the reset cycle itself.
  assign cmac_ready  = ~ytydla_core_rst & (state == ST_ACC) & (issue_cnt < cfg_q.atoms);
  assign beat        = bus.cmac2cacc_valid & cmac_ready;
  assign out_cnt_inc = out_cnt + 1'b1;

  ytydla_cacc_valid_delay #(
    .DEPTH (TREE_LAT)
  ) u_valid_delay (
    .ytydla_core_clk (ytydla_core_clk),
    .ytydla_core_rst (ytydla_core_rst),
    .push            (beat),
    .tail            (tail)
  );

  // NOTE: every always_comb output is given a default first so no latch is inferred.
  always_comb begin
    recv_cnt_nxt = recv_cnt;
    acc_nxt      = acc;
    if (tail) begin
      recv_cnt_nxt = recv_cnt + 1'b1;
      acc_nxt      = acc + bus.tree_sum;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every read
  // in this block sees the value from before the clock edge.
  always_ff @(posedge ytydla_core_clk) begin
    if (ytydla_core_rst) begin
      state     <= ST_IDLE;
      cfg_q     <= '0;
      out_cnt   <= '0;
      issue_cnt <= '0;
      recv_cnt  <= '0;
      acc       <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      req_q     <= 1'b0;
      addr_q    <= '0;
      valid_q   <= 1'b0;
      dat_q     <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cfg_start) begin
            cfg_q   <= '{atoms: cfg_atoms, outputs: cfg_outputs, bias_base: cfg_bias_base};
            out_cnt <= '0;
            if (cfg_outputs == '0) begin
              done_q <= 1'b1;
            end else begin
              state  <= ST_BIAS_REQ;
              busy_q <= 1'b1;
              req_q  <= 1'b1;
              addr_q <= cfg_bias_base;
            end
          end
        end

        ST_BIAS_REQ: begin
          req_q <= 1'b0;
          state <= ST_BIAS_WAIT;
        end

        ST_BIAS_WAIT: begin
          if (bus.mem2cacc_bias_valid) begin
            acc       <= bus.mem2cacc_bias;
            issue_cnt <= '0;
            recv_cnt  <= '0;
            state     <= ST_ACC;
          end
        end

        ST_ACC: begin
          if (beat) begin
            issue_cnt <= issue_cnt + 1'b1;
          end
          acc      <= acc_nxt;
          recv_cnt <= recv_cnt_nxt;
          // Leaving only once every issued beat has returned keeps the tree empty elsewhere.
          if (recv_cnt_nxt == cfg_q.atoms) begin
            state   <= ST_OUT;
            valid_q <= 1'b1;
            dat_q   <= acc_nxt;
          end
        end

        ST_OUT: begin
          if (bus.cact2cacc_ready) begin
            valid_q <= 1'b0;
            out_cnt <= out_cnt_inc;
            if (out_cnt_inc == cfg_q.outputs) begin
              state  <= ST_IDLE;
              busy_q <= 1'b0;
              done_q <= 1'b1;
            end else begin
              state  <= ST_BIAS_REQ;
              req_q  <= 1'b1;
              addr_q <= cfg_q.bias_base + ADDR_W'(out_cnt_inc);
            end
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

  assign ctrl_busy              = busy_q;
  assign ctrl_done              = done_q;
  assign bus.cacc2cmac_ready    = cmac_ready;
  assign bus.cacc2mem_bias_req  = req_q;
  assign bus.cacc2mem_bias_addr = addr_q;
  assign bus.cacc2cact_valid    = valid_q;
  assign bus.cacc2cact_dat      = dat_q;

endmodule
